// File: rtl/bcd_conversion_arbiter.sv
// Round-robin arbiter sharing one binary-to-BCD converter between NUM_REQ requesters.
// One conversion in flight; oversize values saturate locally, a silent converter times out.
module bcd_conversion_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned MAX_VAL = 9999,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [16*NUM_REQ-1:0]  req_value,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  output logic [2:0]             rsp_id,
  output logic [15:0]            rsp_bcd,
  output logic                   rsp_sat,
  output logic                   rsp_err,
  output logic                   conv_start,
  output logic [15:0]            conv_value,
  input  logic                   conv_done,
  input  logic [15:0]            conv_bcd,
  output logic                   busy,
  output logic                   timeout_err
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e     state_q;
  logic [2:0] ptr_q;
  logic [2:0] id_q;
  logic [7:0] cnt_q;

  logic [7:0]  vld_ext;
  logic        gnt_found;
  logic [2:0]  gnt_idx;
  logic [15:0] gnt_val;
  logic        gnt_sat;
  logic [2:0]  ptr_nxt;

  // First valid requester at or after the pointer, wrapping at NUM_REQ.
  always_comb begin
    vld_ext   = 8'(req_valid);
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && vld_ext[3'((32'(ptr_q) + i) % NUM_REQ)]) begin
        gnt_found = 1'b1;
        gnt_idx   = 3'((32'(ptr_q) + i) % NUM_REQ);
      end
    end
    gnt_val = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == 3'(i)) gnt_val = req_value[16*i +: 16];
    end
    gnt_sat = 32'(gnt_val) > MAX_VAL;
    ptr_nxt = (32'(gnt_idx) == NUM_REQ - 1) ? 3'd0 : gnt_idx + 3'd1;
  end

  assign req_ready = (state_q == StIdle && gnt_found) ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign busy      = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_bcd     <= '0;
      rsp_sat     <= 1'b0;
      rsp_err     <= 1'b0;
      conv_start  <= 1'b0;
      conv_value  <= '0;
      timeout_err <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt_found) begin
            id_q  <= gnt_idx;
            ptr_q <= ptr_nxt;
            if (gnt_sat) begin
              state_q   <= StResp;
              rsp_valid <= 1'b1;
              rsp_id    <= gnt_idx;
              rsp_bcd   <= 16'h9999;
              rsp_sat   <= 1'b1;
            end else begin
              state_q    <= StIssue;
              conv_start <= 1'b1;
              conv_value <= gnt_val;
            end
          end
        end
        StIssue: begin
          conv_start <= 1'b0;
          cnt_q      <= '0;
          state_q    <= StWait;
        end
        StWait: begin
          // A done on the final counted cycle still wins over the timeout.
          if (conv_done) begin
            state_q   <= StResp;
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_bcd   <= conv_bcd;
          end else begin
            cnt_q <= cnt_q + 8'd1;
            if (cnt_q == 8'(TIMEOUT - 1)) begin
              state_q     <= StResp;
              rsp_valid   <= 1'b1;
              rsp_id      <= id_q;
              rsp_bcd     <= 16'h0000;
              rsp_err     <= 1'b1;
              timeout_err <= 1'b1;
            end
          end
        end
        StResp: begin
          rsp_valid <= 1'b0;
          rsp_sat   <= 1'b0;
          rsp_err   <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conversion_arbiter.sv
// Directed bench for bcd_conversion_arbiter with a behavioural converter of programmable delay.
module tb_bcd_conversion_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_value = '0;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [2:0]  rsp_id;
  logic [15:0] rsp_bcd;
  logic        rsp_sat, rsp_err, conv_start;
  logic [15:0] conv_value;
  logic        conv_done;
  logic [15:0] conv_bcd;
  logic        busy, timeout_err;

  int errors = 0;
  int checks = 0;

  bcd_conversion_arbiter #(.NUM_REQ(4), .MAX_VAL(9999), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_value(req_value),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_bcd(rsp_bcd),
    .rsp_sat(rsp_sat), .rsp_err(rsp_err), .conv_start(conv_start), .conv_value(conv_value),
    .conv_done(conv_done), .conv_bcd(conv_bcd), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Converter model: done appears conv_delay cycles after the start cycle; 0 = never.
  int          conv_delay = 0;
  int          cv_cnt = 0;
  logic [15:0] cv_val = '0;

  function automatic logic [15:0] to_bcd(input logic [15:0] v);
    int x;
    x = int'(v);
    return {4'((x / 1000) % 10), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  assign conv_done = (cv_cnt == 1);
  assign conv_bcd  = to_bcd(cv_val);

  int cyc = 0;
  int t_start = -1;
  int n_start = 0;
  int n_ready [4] = '{0, 0, 0, 0};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (conv_start) begin
      n_start <= n_start + 1;
      t_start <= cyc;
      cv_cnt  <= conv_delay;
      cv_val  <= conv_value;
    end else if (cv_cnt != 0) begin
      cv_cnt <= cv_cnt - 1;
    end
    for (int i = 0; i < 4; i++) if (req_ready[i]) n_ready[i] <= n_ready[i] + 1;
  end

  // Present one request for a single cycle; returns req_ready seen in the grant cycle.
  task automatic issue(input int idx, input logic [15:0] v, input int d, output logic [3:0] rdy);
    @(negedge clk);
    conv_delay = d;
    req_value[16*idx +: 16] = v;
    req_valid = 4'(1 << idx);
    #1;
    rdy = req_ready;
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic wait_rsp(input int budget, output bit got);
    got = 1'b0;
    if (rsp_valid) got = 1'b1;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, rsp_valid, rsp_sat, rsp_err, conv_start, timeout_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000",
               {busy, rsp_valid, rsp_sat, rsp_err, conv_start, timeout_err});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({rsp_bcd, conv_value, rsp_id, req_ready} !== 39'b0) begin
      errors++;
      $display("FAIL reset_data: bcd=%h val=%h id=%0d rdy=%b want all 0",
               rsp_bcd, conv_value, rsp_id, req_ready);
    end
  endtask

  task automatic test_single();
    logic [3:0] rdy;
    bit got;
    int s0;
    s0 = n_start;
    issue(0, 16'd1234, 9, rdy);
    req_value[15:0] = 16'd5555;
    checks++;
    if (rdy !== 4'b0001) begin
      errors++;
      $display("FAIL single_ready: got %b want 0001", rdy);
    end
    wait_rsp(40, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL single_rsp_timeout: got no rsp_valid want rsp_valid");
    end
    checks++;
    if ({rsp_id, rsp_bcd, rsp_sat, rsp_err} !== {3'd0, 16'h1234, 2'b00}) begin
      errors++;
      $display("FAIL single_rsp: got id=%0d bcd=%h sat=%b err=%b want id=0 bcd=1234 sat=0 err=0",
               rsp_id, rsp_bcd, rsp_sat, rsp_err);
    end
    checks++;
    if (cyc - t_start !== 10) begin
      errors++;
      $display("FAIL single_latency: got %0d want 10", cyc - t_start);
    end
    checks++;
    if (n_start - s0 !== 1 || n_ready[0] !== 1) begin
      errors++;
      $display("FAIL single_pulses: got starts=%0d ready0=%0d want 1 1", n_start - s0, n_ready[0]);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_id [5] = '{0, 1, 2, 3, 0};
    logic [15:0] exp_bcd [5] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0010};
    int r0 [4];
    bit got;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) r0[i] = n_ready[i];
    conv_delay = 2;
    req_value = {16'd40, 16'd30, 16'd20, 16'd10};
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      wait_rsp(40, got);
      if (k == 4) req_valid = '0;
      checks++;
      if (!got || {1'b0, rsp_id} !== exp_id[k] || rsp_bcd !== exp_bcd[k]) begin
        errors++;
        $display("FAIL rr_rsp%0d: got valid=%b id=%0d bcd=%h want id=%0d bcd=%h",
                 k, got, rsp_id, rsp_bcd, exp_id[k], exp_bcd[k]);
      end
    end
    checks++;
    if (n_ready[0] - r0[0] !== 2 || n_ready[1] - r0[1] !== 1 ||
        n_ready[2] - r0[2] !== 1 || n_ready[3] - r0[3] !== 1) begin
      errors++;
      $display("FAIL rr_grants: got %0d %0d %0d %0d want 2 1 1 1", n_ready[0] - r0[0],
               n_ready[1] - r0[1], n_ready[2] - r0[2], n_ready[3] - r0[3]);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] rdy;
    bit got;
    int s0;
    @(negedge clk);
    s0 = n_start;
    issue(2, 16'd10000, 3, rdy);
    checks++;
    if (rdy !== 4'b0100 || rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL sat_timing: got rdy=%b rsp_valid=%b want 0100 1", rdy, rsp_valid);
    end
    checks++;
    if ({rsp_id, rsp_bcd, rsp_sat, rsp_err} !== {3'd2, 16'h9999, 2'b10}) begin
      errors++;
      $display("FAIL sat_rsp: got id=%0d bcd=%h sat=%b err=%b want id=2 bcd=9999 sat=1 err=0",
               rsp_id, rsp_bcd, rsp_sat, rsp_err);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_sat !== 1'b0 || rsp_bcd !== 16'h9999 || n_start !== s0) begin
      errors++;
      $display("FAIL sat_after: got valid=%b sat=%b bcd=%h starts=%0d want 0 0 9999 %0d",
               rsp_valid, rsp_sat, rsp_bcd, n_start, s0);
    end
    issue(2, 16'd9999, 3, rdy);
    wait_rsp(40, got);
    checks++;
    if (!got || rsp_bcd !== 16'h9999 || rsp_sat !== 1'b0 || n_start - s0 !== 1) begin
      errors++;
      $display("FAIL sat_max_val: got valid=%b bcd=%h sat=%b starts=%0d want 1 9999 0 1",
               got, rsp_bcd, rsp_sat, n_start - s0);
    end
  endtask

  task automatic test_timeout();
    logic [3:0] rdy;
    bit got;
    @(negedge clk);
    issue(1, 16'd42, 0, rdy);
    wait_rsp(60, got);
    checks++;
    if (!got || rsp_err !== 1'b1 || rsp_bcd !== 16'h0000 || rsp_id !== 3'd1 ||
        timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL to_rsp: got valid=%b err=%b bcd=%h id=%0d sticky=%b want 1 1 0000 1 1",
               got, rsp_err, rsp_bcd, rsp_id, timeout_err);
    end
    checks++;
    if (cyc - t_start !== 16) begin
      errors++;
      $display("FAIL to_latency: got %0d want 16", cyc - t_start);
    end
    @(negedge clk);
    checks++;
    if (rsp_err !== 1'b0 || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL to_sticky: got err=%b sticky=%b want 0 1", rsp_err, timeout_err);
    end
    issue(3, 16'd77, 2, rdy);
    wait_rsp(40, got);
    checks++;
    if (!got || rsp_bcd !== 16'h0077 || rsp_err !== 1'b0 || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL to_next: got valid=%b bcd=%h err=%b sticky=%b want 1 0077 0 1",
               got, rsp_bcd, rsp_err, timeout_err);
    end
  endtask

  task automatic test_done_boundary();
    logic [3:0] rdy;
    bit got;
    @(negedge clk);
    issue(0, 16'd4321, 15, rdy);
    wait_rsp(60, got);
    checks++;
    if (!got || rsp_err !== 1'b0 || rsp_bcd !== 16'h4321 || cyc - t_start !== 16) begin
      errors++;
      $display("FAIL edge_done: got valid=%b err=%b bcd=%h lat=%0d want 1 0 4321 16",
               got, rsp_err, rsp_bcd, cyc - t_start);
    end
    @(negedge clk);
    issue(0, 16'd4321, 16, rdy);
    wait_rsp(60, got);
    checks++;
    if (!got || rsp_err !== 1'b1 || rsp_bcd !== 16'h0000) begin
      errors++;
      $display("FAIL edge_late: got valid=%b err=%b bcd=%h want 1 1 0000", got, rsp_err, rsp_bcd);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [3:0] rdy;
    bit got;
    bit saw;
    @(negedge clk);
    issue(2, 16'd321, 8, rdy);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) saw = 1'b1;
    end
    checks++;
    if (saw) begin
      errors++;
      $display("FAIL rst_wait_rsp: got rsp_valid=1 want 0");
    end
    checks++;
    if ({busy, rsp_valid, rsp_sat, rsp_err, conv_start, timeout_err} !== 6'b0 ||
        {rsp_bcd, conv_value, rsp_id} !== 35'b0) begin
      errors++;
      $display("FAIL rst_wait_outs: flags=%b bcd=%h val=%h id=%0d want all 0",
               {busy, rsp_valid, rsp_sat, rsp_err, conv_start, timeout_err},
               rsp_bcd, conv_value, rsp_id);
    end
    @(negedge clk);
    conv_delay = 2;
    req_value = {16'd6, 16'd0, 16'd0, 16'd5};
    req_valid = 4'b1001;
    #1;
    rdy = req_ready;
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (rdy !== 4'b0001) begin
      errors++;
      $display("FAIL rst_wait_ptr: got %b want 0001", rdy);
    end
    wait_rsp(40, got);
    checks++;
    if (!got || rsp_id !== 3'd0 || rsp_bcd !== 16'h0005) begin
      errors++;
      $display("FAIL rst_wait_next: got valid=%b id=%0d bcd=%h want 1 0 0005", got, rsp_id, rsp_bcd);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_saturation();
    test_timeout();
    test_done_boundary();
    test_reset_in_wait();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
